// File: rtl/frame_decoder.sv
// ETROC2 word-stream frame decoder: classifies aligned 40-bit words, walks frames, emits hits and frame summaries.
// Optional CRC-8 frame check is compiled in when CRC_CHECK_EN is defined.
module frame_decoder #(
  parameter logic [15:0] HEADER_ID = 16'h3C5C,
  parameter int unsigned MAX_HITS  = 16,
  parameter logic [7:0]  CRC_POLY  = 8'h2F
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [39:0] WordIn,
  input  logic        WordValid,
  input  logic        Aligned,
  output logic        HitValid,
  output logic [1:0]  HitEA,
  output logic [3:0]  HitCol,
  output logic [3:0]  HitRow,
  output logic [9:0]  HitTOA,
  output logic [8:0]  HitTOT,
  output logic [9:0]  HitCAL,
  output logic [7:0]  FrameL1Counter,
  output logic [1:0]  FrameType,
  output logic [11:0] FrameBCID,
  output logic        FrameDone,
  output logic [16:0] FrameChipId,
  output logic [5:0]  FrameStatus,
  output logic [7:0]  FrameHits,
  output logic        HitCountErr,
  output logic        CrcErr,
  output logic        ProtocolErr,
  output logic [23:0] FrameCount,
  output logic [15:0] ErrorCount
);

  localparam logic [7:0] MAX_HITS_W = MAX_HITS[7:0];

  typedef enum logic {
    IDLE,
    PAYLOAD
  } state_t;

  state_t state;
  logic   ovf_seen;

  logic word_ok;
  logic is_header;
  logic is_filler;
  logic is_data;
  logic is_trailer;
  logic in_payload;
  logic start_frame;
  logic take_hit;
  logic take_trailer;
  logic hit_overflow;
  logic prot_err;
  logic hit_cnt_bad;
  logic crc_bad;
  logic err_event;

  always_comb begin
    word_ok      = WordValid & Aligned;
    is_header    = (WordIn[39:22] == {HEADER_ID, 2'b00});
    is_filler    = (WordIn[39:22] == {HEADER_ID, 2'b10});
    is_data      = WordIn[39] & ~is_header & ~is_filler;
    is_trailer   = ~WordIn[39] & ~is_header & ~is_filler;
    in_payload   = (state == PAYLOAD);
    start_frame  = word_ok & is_header;
    take_hit     = word_ok & in_payload & is_data;
    take_trailer = word_ok & in_payload & is_trailer;
    // Only the first hit beyond MAX_HITS flags; later ones in the same frame are silent.
    hit_overflow = take_hit & (FrameHits == MAX_HITS_W) & ~ovf_seen;
    prot_err     = word_ok & ((~in_payload & (is_data | is_trailer)) |
                              (in_payload & (is_header | is_filler)) |
                              hit_overflow);
    hit_cnt_bad  = (FrameHits != WordIn[15:8]);
    err_event    = prot_err | (take_trailer & (hit_cnt_bad | crc_bad));
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state          <= IDLE;
      ovf_seen       <= 1'b0;
      HitValid       <= 1'b0;
      HitEA          <= '0;
      HitCol         <= '0;
      HitRow         <= '0;
      HitTOA         <= '0;
      HitTOT         <= '0;
      HitCAL         <= '0;
      FrameL1Counter <= '0;
      FrameType      <= '0;
      FrameBCID      <= '0;
      FrameDone      <= 1'b0;
      FrameChipId    <= '0;
      FrameStatus    <= '0;
      FrameHits      <= '0;
      HitCountErr    <= 1'b0;
      ProtocolErr    <= 1'b0;
      FrameCount     <= '0;
      ErrorCount     <= '0;
    end else begin
      HitValid    <= 1'b0;
      FrameDone   <= 1'b0;
      HitCountErr <= 1'b0;
      ProtocolErr <= prot_err;

      case (state)
        IDLE:    if (start_frame) state <= PAYLOAD;
        PAYLOAD: if (word_ok && (is_filler || is_trailer)) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (!Aligned) state <= IDLE;

      if (start_frame) begin
        FrameL1Counter <= WordIn[21:14];
        FrameType      <= WordIn[13:12];
        FrameBCID      <= WordIn[11:0];
        FrameHits      <= '0;
        ovf_seen       <= 1'b0;
      end

      if (take_hit) begin
        HitValid <= 1'b1;
        HitEA    <= WordIn[38:37];
        HitCol   <= WordIn[36:33];
        HitRow   <= WordIn[32:29];
        HitTOA   <= WordIn[28:19];
        HitTOT   <= WordIn[18:10];
        HitCAL   <= WordIn[9:0];
        if (FrameHits != 8'hFF) FrameHits <= FrameHits + 8'd1;
        if (hit_overflow) ovf_seen <= 1'b1;
      end

      if (take_trailer) begin
        FrameDone   <= 1'b1;
        FrameChipId <= WordIn[38:22];
        FrameStatus <= WordIn[21:16];
        HitCountErr <= hit_cnt_bad;
        FrameCount  <= FrameCount + 24'd1;
      end

      if (err_event && (ErrorCount != 16'hFFFF)) ErrorCount <= ErrorCount + 16'd1;
    end
  end

`ifdef CRC_CHECK_EN
  logic [7:0] crc_q;
  logic       crc_err_q;

  function automatic logic [7:0] crc_step(input logic [7:0] crc_in, input logic [39:0] word,
                                          input int unsigned nbits);
    logic [7:0]  c;
    logic [39:0] w;
    logic        fb;
    c = crc_in;
    w = word;
    for (int unsigned i = 0; i < 40; i++) begin
      if (i < nbits) begin
        fb = c[7] ^ w[39];
        c  = {c[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
        w  = {w[38:0], 1'b0};
      end
    end
    return c;
  endfunction

  // The trailer contributes only its upper 32 bits; its low byte carries the expected CRC.
  always_comb crc_bad = (crc_step(crc_q, WordIn, 32) != WordIn[7:0]);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      crc_q     <= '0;
      crc_err_q <= 1'b0;
    end else begin
      crc_err_q <= take_trailer & crc_bad;
      if (start_frame)   crc_q <= crc_step(8'h00, WordIn, 40);
      else if (take_hit) crc_q <= crc_step(crc_q, WordIn, 40);
    end
  end

  assign CrcErr = crc_err_q;
`else
  logic [7:0] unused_crc_poly;
  assign unused_crc_poly = CRC_POLY;
  assign crc_bad         = 1'b0;
  assign CrcErr          = 1'b0;
`endif

endmodule

// File: tb/tb_frame_decoder.sv
// Self-checking bench for frame_decoder: directed frames against a word-level reference model.
module tb_frame_decoder;

  localparam logic [15:0] HID  = 16'h3C5C;
  localparam int          MAXH = 16;
`ifdef CRC_CHECK_EN
  localparam int CE = 1;
`else
  localparam int CE = 0;
`endif

  typedef bit bitbuf_t [0:1023];

  logic        CLK;
  logic        RSTn;
  logic [39:0] WordIn;
  logic        WordValid;
  logic        Aligned;
  logic        HitValid;
  logic [1:0]  HitEA;
  logic [3:0]  HitCol;
  logic [3:0]  HitRow;
  logic [9:0]  HitTOA;
  logic [8:0]  HitTOT;
  logic [9:0]  HitCAL;
  logic [7:0]  FrameL1Counter;
  logic [1:0]  FrameType;
  logic [11:0] FrameBCID;
  logic        FrameDone;
  logic [16:0] FrameChipId;
  logic [5:0]  FrameStatus;
  logic [7:0]  FrameHits;
  logic        HitCountErr;
  logic        CrcErr;
  logic        ProtocolErr;
  logic [23:0] FrameCount;
  logic [15:0] ErrorCount;

  frame_decoder #(
    .HEADER_ID(HID),
    .MAX_HITS (MAXH),
    .CRC_POLY (8'h2F)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .WordIn(WordIn), .WordValid(WordValid), .Aligned(Aligned),
    .HitValid(HitValid), .HitEA(HitEA), .HitCol(HitCol), .HitRow(HitRow),
    .HitTOA(HitTOA), .HitTOT(HitTOT), .HitCAL(HitCAL),
    .FrameL1Counter(FrameL1Counter), .FrameType(FrameType), .FrameBCID(FrameBCID),
    .FrameDone(FrameDone), .FrameChipId(FrameChipId), .FrameStatus(FrameStatus),
    .FrameHits(FrameHits), .HitCountErr(HitCountErr), .CrcErr(CrcErr),
    .ProtocolErr(ProtocolErr), .FrameCount(FrameCount), .ErrorCount(ErrorCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // CRC as polynomial long division of message*x^8 by x^8+x^5+x^3+x^2+x+1.
  function automatic logic [7:0] crc_div(input bitbuf_t m, input int len);
    bit         a [0:1031];
    bit   [8:0] g;
    logic [7:0] r;
    g = 9'h12F;
    for (int i = 0; i < 1032; i++) a[i] = (i < len) ? m[i] : 1'b0;
    for (int i = 0; i < len; i++)
      if (a[i]) for (int j = 0; j < 9; j++) a[i+j] ^= g[8-j];
    for (int k = 0; k < 8; k++) r[7-k] = a[len+k];
    return r;
  endfunction

  // Reference model state
  bitbuf_t     m_buf;
  int          m_len;
  bit          m_in_frame;
  int          m_n;
  logic        m_hv, m_done, m_hce, m_crce, m_perr;
  logic [1:0]  m_ea;
  logic [3:0]  m_col, m_row;
  logic [9:0]  m_toa, m_cal;
  logic [8:0]  m_tot;
  logic [7:0]  m_l1, m_hits;
  logic [1:0]  m_type;
  logic [11:0] m_bcid;
  logic [16:0] m_chip;
  logic [5:0]  m_status;
  logic [23:0] m_fc;
  logic [15:0] m_ec;

  task automatic m_push(input logic [39:0] w, input int nbits);
    for (int b = 0; b < nbits; b++)
      if (m_len < 1024) begin m_buf[m_len] = w[39-b]; m_len++; end
  endtask

  task automatic model_step(input logic [39:0] w, input logic v, input logic al, input logic rn);
    bit hdr, fil, dat;
    if (!rn) begin
      m_in_frame = 0; m_n = 0; m_len = 0;
      {m_hv, m_done, m_hce, m_crce, m_perr} = '0;
      m_ea = '0; m_col = '0; m_row = '0; m_toa = '0; m_tot = '0; m_cal = '0;
      m_l1 = '0; m_type = '0; m_bcid = '0; m_hits = '0; m_chip = '0; m_status = '0;
      m_fc = '0; m_ec = '0;
      return;
    end
    {m_hv, m_done, m_hce, m_crce, m_perr} = '0;
    if (!al) begin m_in_frame = 0; return; end
    if (!v) return;
    hdr = (w[39:22] == {HID, 2'b00});
    fil = (w[39:22] == {HID, 2'b10});
    dat = w[39] && !hdr && !fil;
    if (hdr) begin
      if (m_in_frame) m_perr = 1;
      m_in_frame = 1; m_n = 0; m_hits = '0; m_len = 0;
      m_l1 = w[21:14]; m_type = w[13:12]; m_bcid = w[11:0];
      m_push(w, 40);
    end else if (fil) begin
      if (m_in_frame) begin m_perr = 1; m_in_frame = 0; end
    end else if (!m_in_frame) begin
      m_perr = 1;
    end else if (dat) begin
      m_hv = 1;
      m_ea = w[38:37]; m_col = w[36:33]; m_row = w[32:29];
      m_toa = w[28:19]; m_tot = w[18:10]; m_cal = w[9:0];
      m_n++;
      m_hits = (m_n > 255) ? 8'hFF : 8'(m_n);
      if (m_n == MAXH + 1) m_perr = 1;
      m_push(w, 40);
    end else begin
      m_done = 1; m_in_frame = 0;
      m_chip = w[38:22]; m_status = w[21:16];
      m_hce = (m_hits != w[15:8]);
      m_push(w, 32);
`ifdef CRC_CHECK_EN
      m_crce = (crc_div(m_buf, m_len) != w[7:0]);
`else
      m_crce = 0;
`endif
      m_fc = m_fc + 24'd1;
    end
    if ((m_perr || (m_done && (m_hce || m_crce))) && m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
  endtask

  int cnt_hit = 0, cnt_done = 0, cnt_prot = 0, cnt_hce = 0, cnt_crce = 0;

  always @(posedge CLK) begin
    logic [39:0] cw;
    logic cv, ca, cr;
    cw = WordIn; cv = WordValid; ca = Aligned; cr = RSTn;
    #1;
    model_step(cw, cv, ca, cr);
    chk("HitValid", HitValid, m_hv);
    chk("HitEA", HitEA, m_ea);
    chk("HitCol", HitCol, m_col);
    chk("HitRow", HitRow, m_row);
    chk("HitTOA", HitTOA, m_toa);
    chk("HitTOT", HitTOT, m_tot);
    chk("HitCAL", HitCAL, m_cal);
    chk("FrameL1Counter", FrameL1Counter, m_l1);
    chk("FrameType", FrameType, m_type);
    chk("FrameBCID", FrameBCID, m_bcid);
    chk("FrameDone", FrameDone, m_done);
    chk("FrameChipId", FrameChipId, m_chip);
    chk("FrameStatus", FrameStatus, m_status);
    chk("FrameHits", FrameHits, m_hits);
    chk("HitCountErr", HitCountErr, m_hce);
    chk("CrcErr", CrcErr, m_crce);
    chk("ProtocolErr", ProtocolErr, m_perr);
    chk("FrameCount", FrameCount, m_fc);
    chk("ErrorCount", ErrorCount, m_ec);
    if (HitValid === 1'b1)    cnt_hit++;
    if (FrameDone === 1'b1)   cnt_done++;
    if (ProtocolErr === 1'b1) cnt_prot++;
    if (HitCountErr === 1'b1) cnt_hce++;
    if (CrcErr === 1'b1)      cnt_crce++;
  end

  // Stimulus side
  bitbuf_t s_buf;
  int      s_len = 0;

  function automatic logic [39:0] mk_hdr(input logic [7:0] l1, input logic [1:0] ty,
                                         input logic [11:0] bcid);
    return {HID, 2'b00, l1, ty, bcid};
  endfunction

  function automatic logic [39:0] mk_data(input int k);
    return {1'b1, 2'(k), 4'(k + 1), 4'(k + 2), 10'(k * 37 + 1), 9'(k * 11 + 5), 10'(k * 3 + 200)};
  endfunction

  function automatic logic [39:0] mk_trl(input logic [16:0] chip, input logic [5:0] st,
                                         input logic [7:0] hits, input logic [7:0] crc);
    return {1'b0, chip, st, hits, crc};
  endfunction

  task automatic s_push(input logic [39:0] w, input int nbits);
    for (int b = 0; b < nbits; b++)
      if (s_len < 1024) begin s_buf[s_len] = w[39-b]; s_len++; end
  endtask

  task automatic send_raw(input logic [39:0] w);
    @(negedge CLK);
    WordIn = w; WordValid = 1'b1;
  endtask

  task automatic send_word(input logic [39:0] w);
    if (w[39:22] == {HID, 2'b00}) s_len = 0;
    s_push(w, 40);
    send_raw(w);
  endtask

  task automatic send_trailer(input logic [7:0] hits, input bit flip);
    logic [39:0] t;
    logic [7:0]  c;
    t = mk_trl(17'h1ABCD, 6'h2A, hits, 8'h00);
    s_push(t, 32);
    c = crc_div(s_buf, s_len);
    if (flip) c = c ^ 8'h01;
    send_raw({t[39:8], c});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      WordValid = 1'b0; WordIn = {$urandom, 8'($urandom)};
    end
  endtask

  task automatic send_frame(input logic [7:0] l1, input logic [11:0] bcid, input int n,
                            input logic [7:0] trl_hits, input bit flip, input bit gap);
    send_word(mk_hdr(l1, 2'b01, bcid));
    for (int k = 0; k < n; k++) begin
      send_word(mk_data(k));
      if (gap && k == 0) idle(1);
    end
    send_trailer(trl_hits, flip);
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got still running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bitbuf_t pin;
    RSTn = 1'b1; WordIn = '0; WordValid = 1'b0; Aligned = 1'b1;
    #2 RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;

    for (int i = 0; i < 1024; i++) pin[i] = 1'b0;
    pin[7] = 1'b1;
    chk("pin_crc_model_01", crc_div(pin, 8), 8'h2F);
    pin[7] = 1'b0; pin[6] = 1'b1;
    chk("pin_crc_model_02", crc_div(pin, 8), 8'h5E);

    chk("reset_FrameCount", FrameCount, 0);
    chk("reset_ErrorCount", ErrorCount, 0);
    chk("reset_HitValid", HitValid, 0);

    send_frame(8'h12, 12'h345, 3, 8'd3, 1'b0, 1'b1);
    chk("A_hits_seen", cnt_hit, 3);
    chk("A_done_seen", cnt_done, 1);
    chk("A_FrameCount", FrameCount, 1);
    chk("A_FrameHits", FrameHits, 3);
    chk("A_L1", FrameL1Counter, 8'h12);
    chk("A_BCID", FrameBCID, 12'h345);
    chk("A_ErrorCount", ErrorCount, 0);

    send_frame(8'h12, 12'h345, 3, 8'd2, 1'b0, 1'b0);
    chk("B_hce_seen", cnt_hce, 1);
    chk("B_ErrorCount", ErrorCount, 1);
    chk("B_FrameCount", FrameCount, 2);

    send_frame(8'h20, 12'h010, 2, 8'd2, 1'b1, 1'b0);
    chk("C_crce_seen", cnt_crce, CE);
    chk("C_ErrorCount", ErrorCount, 1 + CE);
    send_frame(8'h21, 12'h011, 2, 8'd2, 1'b0, 1'b0);
    chk("D_crce_seen", cnt_crce, CE);
    chk("D_FrameCount", FrameCount, 4);

    send_word({HID, 2'b10, 22'h2AAAA});
    send_word(mk_data(5));
    idle(2);
    chk("idle_data_prot", cnt_prot, 1);
    chk("idle_data_ErrorCount", ErrorCount, 2 + CE);

    send_word(mk_hdr(8'h30, 2'b10, 12'hABC));
    send_word(mk_data(1));
    send_word({HID, 2'b10, 22'h15555});
    idle(2);
    chk("drop_prot", cnt_prot, 2);
    chk("drop_no_done", cnt_done, 4);
    send_frame(8'h31, 12'h001, 1, 8'd1, 1'b0, 1'b0);
    chk("E_FrameCount", FrameCount, 5);
    chk("E_ErrorCount", ErrorCount, 3 + CE);

    send_frame(8'h40, 12'hFFF, MAXH + 1, 8'd17, 1'b0, 1'b0);
    chk("F_prot_once", cnt_prot, 3);
    chk("F_FrameHits", FrameHits, 17);
    chk("F_FrameCount", FrameCount, 6);
    chk("F_hits_seen", cnt_hit, 29);

    send_word(mk_hdr(8'hAA, 2'b00, 12'h100));
    send_word(mk_data(2));
    send_word(mk_hdr(8'hBB, 2'b11, 12'h0FF));
    send_word(mk_data(3));
    send_trailer(8'd1, 1'b0);
    idle(2);
    chk("restart_prot", cnt_prot, 4);
    chk("restart_L1", FrameL1Counter, 8'hBB);
    chk("restart_FrameHits", FrameHits, 1);
    chk("restart_FrameCount", FrameCount, 7);
    chk("restart_ErrorCount", ErrorCount, 5 + CE);

    send_word(mk_hdr(8'h50, 2'b01, 12'h222));
    send_word(mk_data(4));
    @(negedge CLK); Aligned = 1'b0; WordIn = mk_data(6); WordValid = 1'b1;
    @(negedge CLK); WordIn = mk_trl(17'h1ABCD, 6'h2A, 8'd1, 8'h00);
    @(negedge CLK); Aligned = 1'b1; WordValid = 1'b0;
    send_word(mk_data(7));
    idle(2);
    chk("align_hits_seen", cnt_hit, 32);
    chk("align_prot", cnt_prot, 5);
    chk("align_FrameCount", FrameCount, 7);

    send_word(mk_hdr(8'h60, 2'b01, 12'h333));
    send_word(mk_data(8));
    @(negedge CLK); WordValid = 1'b0; RSTn = 1'b0;
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    chk("rst_FrameCount", FrameCount, 0);
    chk("rst_ErrorCount", ErrorCount, 0);
    chk("rst_FrameHits", FrameHits, 0);
    chk("rst_L1", FrameL1Counter, 0);
    chk("rst_HitCAL", HitCAL, 0);

    send_frame(8'h70, 12'h444, 2, 8'd2, 1'b0, 1'b0);
    chk("G_FrameCount", FrameCount, 1);
    chk("G_ErrorCount", ErrorCount, 0);

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
